// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches words from a synchronous ROM and plays LED/PWM
// patterns with timed waits, jumps and a single counted loop.
module ucode_sequencer #(
  parameter int ADDR_W   = 9,
  parameter int VEC_W    = 12,
  parameter int PWM_CH   = 2,
  parameter int PWM_W    = 4,
  parameter int PRESCALE = 1000,
  parameter int RESET_PC = 0,
  localparam int INSTR_W = PWM_CH*PWM_W + VEC_W + 2 + ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [INSTR_W-1:0]        rom_data,
  output logic [VEC_W-1:0]          vec,
  output logic [PWM_CH*PWM_W-1:0]   pwm,
  output logic [ADDR_W-1:0]         pc
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT} state_e;
  typedef enum logic [1:0] {OP_WAIT = 2'b00, OP_JUMP = 2'b01, OP_LDCNT = 2'b10, OP_LOOP = 2'b11} op_e;

  typedef struct packed {
    logic [PWM_CH*PWM_W-1:0] pwm;
    logic [VEC_W-1:0]        vec;
    op_e                     op;
    logic [ADDR_W-1:0]       arg;
  } instr_t;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_e                  state, state_n;
  logic [ADDR_W-1:0]       pc_n, pc_inc;
  logic [ADDR_W-1:0]       loop_cnt, loop_cnt_n;
  logic [ADDR_W-1:0]       wait_cnt, wait_cnt_n;
  logic [PS_W-1:0]         prescaler, prescaler_n;
  logic [VEC_W-1:0]        vec_n;
  logic [PWM_CH*PWM_W-1:0] pwm_n;
  instr_t                  ins;
  logic                    tick;

  assign ins      = instr_t'(rom_data);
  assign rom_en   = run && !reset && (state == S_FETCH);
  assign rom_addr = pc;
  assign pc_inc   = pc + ADDR_W'(1);
  assign tick     = (prescaler == PS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= ADDR_W'(RESET_PC);
      vec       <= '0;
      pwm       <= '0;
      loop_cnt  <= '0;
      wait_cnt  <= '0;
      prescaler <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      vec       <= vec_n;
      pwm       <= pwm_n;
      loop_cnt  <= loop_cnt_n;
      wait_cnt  <= wait_cnt_n;
      prescaler <= prescaler_n;
    end
  end

  // Everything holds by default; run=0 simply skips the case and freezes all state.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    vec_n       = vec;
    pwm_n       = pwm;
    loop_cnt_n  = loop_cnt;
    wait_cnt_n  = wait_cnt;
    prescaler_n = prescaler;
    if (run) begin
      case (state)
        S_FETCH: state_n = S_EXEC;
        S_EXEC: begin
          state_n = S_FETCH;
          case (ins.op)
            OP_WAIT: begin
              vec_n = ins.vec;
              pwm_n = ins.pwm;
              if (ins.arg == '0) begin
                pc_n = pc_inc;
              end else begin
                wait_cnt_n  = ins.arg;
                prescaler_n = '0;
                state_n     = S_WAIT;
              end
            end
            OP_JUMP:  pc_n = ins.arg;
            OP_LDCNT: begin
              loop_cnt_n = ins.arg;
              pc_n       = pc_inc;
            end
            OP_LOOP: begin
              if (loop_cnt != '0) begin
                loop_cnt_n = loop_cnt - ADDR_W'(1);
                pc_n       = ins.arg;
              end else begin
                pc_n = pc_inc;
              end
            end
            default: pc_n = pc_inc;
          endcase
        end
        S_WAIT: begin
          if (tick) begin
            prescaler_n = '0;
            if (wait_cnt == ADDR_W'(1)) begin
              pc_n    = pc_inc;
              state_n = S_FETCH;
            end else begin
              wait_cnt_n = wait_cnt - ADDR_W'(1);
            end
          end else begin
            prescaler_n = prescaler + PS_W'(1);
          end
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9: microcode address and operand width.
REQ-002 Parameter VEC_W, default 12: LED vector width.
REQ-003 Parameter PWM_CH, default 2: number of PWM duty channels.
REQ-004 Parameter PWM_W, default 4: duty width per channel.
REQ-005 Parameter PRESCALE, default 1000: clk cycles per wait tick, >=1.
REQ-006 Parameter RESET_PC, default 0: start address after reset.
REQ-007 Derived INSTR_W = PWM_CH*PWM_W + VEC_W + 2 + ADDR_W; word layout MSB->LSB {pwm[PWM_CH-1]..pwm[0], vec, opcode[1:0], operand[ADDR_W-1:0]}.
REQ-008 clk  in  1  sole clock; all state on rising edge.
REQ-009 reset  in  1  synchronous, active-high.
REQ-010 run  in  1  1 = sequencer advances; 0 = pause, all state held.
REQ-011 rom_en  out  1  ROM read strobe.
REQ-012 rom_addr  out  ADDR_W  ROM read address (= pc).
REQ-013 rom_data  in  INSTR_W  ROM word, valid the cycle after rom_en=1.
REQ-014 vec  out  VEC_W  registered LED vector.
REQ-015 pwm  out  PWM_CH*PWM_W  registered duties, channel k at bits [k*PWM_W +: PWM_W].
REQ-016 pc  out  ADDR_W  current program counter.

Function
REQ-017 Opcodes: 00 WAIT n, 01 JUMP a, 10 LDCNT n, 11 LOOP a.
REQ-018 States FETCH, EXEC, WAIT; rom_en=1 only in FETCH with run=1; rom_addr=pc always.
REQ-019 FETCH with run=1 -> EXEC next cycle; EXEC decodes rom_data.
REQ-020 WAIT n in EXEC: vec/pwm loaded from word that edge; n=0 -> pc+1, FETCH; n>0 -> wait_cnt=n, prescaler=0, state WAIT.
REQ-021 In WAIT a tick fires when prescaler reaches PRESCALE-1 (prescaler then wraps to 0); on tick with wait_cnt=1 -> pc+1, FETCH, else wait_cnt-1; WAIT n lasts exactly n*PRESCALE cycles in WAIT state.
REQ-022 JUMP a: pc=a, FETCH; vec/pwm unchanged.
REQ-023 LDCNT n: loop_cnt=n, pc+1, FETCH; vec/pwm unchanged.
REQ-024 LOOP a: loop_cnt!=0 -> loop_cnt-1, pc=a; loop_cnt=0 -> pc+1; then FETCH; body preceding LOOP executes n+1 times after LDCNT n.
REQ-025 Only WAIT updates vec/pwm; no output glitch on control opcodes.
REQ-026 pc+1 wraps modulo 2^ADDR_W (all-ones -> 0).
REQ-027 run=0: state, pc, counters, prescaler, outputs frozen; rom_en=0; resume continues exactly where paused; run=0 in EXEC defers decode (rom_data sampled when run returns, ROM must hold output while rom_en=0).
REQ-028 Instruction cost: WAIT n>0 = 2 + n*PRESCALE cycles; other opcodes = 2 cycles.

Reset
REQ-029 reset=1 at edge: state FETCH, pc=RESET_PC, vec=0, pwm=0, loop_cnt=0, wait_cnt=0, prescaler=0; reset overrides run and any in-flight instruction.
REQ-030 First rom_en=1 is the first cycle after reset deasserts with run=1, rom_addr=RESET_PC.

Verification
REQ-031 PRESCALE=4, ROM[0]=WAIT 3 vec=0xABC pwm={0x5,0xA}, ROM[1]=JUMP 0 -> vec=0xABC/pwm=0x5A one cycle after EXEC, pc=1 after 12 WAIT cycles, pc cycles 0,1,0 with 16-cycle period.
REQ-032 ROM[0]=LDCNT 2, ROM[1]=WAIT 1 vec=k, ROM[2]=LOOP 1, ROM[3]=JUMP 3 -> WAIT at 1 executes 3 times, pc settles at 3, loop_cnt=0.
REQ-033 ADDR_W=3, PRESCALE=1, all ROM words WAIT 0 -> pc sequence 0..7,0 (wrap), each step 2 cycles.
REQ-034 run driven low for 10 cycles mid-WAIT 5 -> prescaler/wait_cnt/pc frozen, total WAIT duration = 5*PRESCALE+10 cycles.
REQ-035 reset pulsed mid-WAIT with vec=0xFFF -> next cycle vec=0, pwm=0, pc=RESET_PC, state FETCH.
REQ-036 JUMP between two WAITs with different vec -> vec transitions once, directly, with no intermediate value.
